// File: rtl/wb_stream_pkg.sv
// Shared definitions for the Wishbone stream writer.
// Holds the FSM state encoding and the Wishbone cycle/burst type constants.
package wb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CLASSIC    = 3'b000;
  localparam logic [2:0] INC        = 3'b010;
  localparam logic [2:0] EOB        = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

endpackage

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone read master that streams a linear memory buffer into an external FIFO.
// Each burst is sized to fit both the requested burst size and the free FIFO space,
// so acked data can be written to the FIFO with no holding register.
// Build option WB_STREAM_WRITER_BURST_EN: incrementing bursts (cti 010/111).
// Without it, classic cycles are issued and stb drops for one cycle after every ack.
//
// state | meaning
// IDLE  | waiting for an enable pulse with non-zero sizes
// WAIT  | waiting for enough FIFO space for the next burst
// BURST | bus cycle active, acked words go straight to the FIFO
// DONE  | whole buffer transferred, one-cycle irq
module wb_stream_writer_ctrl
  import wb_stream_pkg::*;
#(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  output logic [WB_DW-1:0]   fifo_d_o,
  output logic               fifo_wr_o,
  input  logic [FIFO_AW:0]   fifo_cnt_i,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy_o,
  output logic               irq_o,
  output logic               err_o
);

  localparam logic [WB_AW-1:0] ONE_W      = 1;
  localparam logic [WB_AW-1:0] FIFO_DEPTH = ONE_W << FIFO_AW;
  localparam logic [WB_AW-1:0] WORD_BYTES = WB_AW'(WB_DW / 8);

  state_t           state_q, state_d;
  logic [WB_AW-1:0] base_adr_q, buf_size_q, burst_size_q;
  logic [WB_AW-1:0] offset_q, beat_cnt_q, burst_len_q;
  logic             gap_q;

  logic [WB_AW-1:0] remaining, burst_len_c, fifo_space;
  logic             start_ok, last_beat, bus_term, bus_err, beat_ok;

  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = '1;
  assign wbm_bte_o = BTE_LINEAR;
  assign busy_o    = (state_q != IDLE);
  assign wbm_adr_o = base_adr_q + offset_q * WORD_BYTES;
  assign fifo_d_o  = wbm_dat_i;

  assign start_ok   = enable && (buf_size != '0) && (burst_size != '0);
  assign remaining  = buf_size_q - offset_q;
  assign fifo_space = FIFO_DEPTH - {{(WB_AW-FIFO_AW-1){1'b0}}, fifo_cnt_i};
  assign last_beat  = (beat_cnt_q == burst_len_q - ONE_W);

  // A strobe is terminated by ack, err or rty; err wins over ack, rty alone just holds.
  assign bus_term = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign bus_err  = (state_q == BURST) && wbm_stb_o && bus_term && wbm_err_i;
  assign beat_ok  = (state_q == BURST) && wbm_stb_o && bus_term && wbm_ack_i && !wbm_err_i;
  assign fifo_wr_o = beat_ok && !wb_rst_i;

  // Next burst length: smallest of requested size, words left and FIFO depth.
  always_comb begin
    burst_len_c = burst_size_q;
    if (remaining < burst_len_c)  burst_len_c = remaining;
    if (FIFO_DEPTH < burst_len_c) burst_len_c = FIFO_DEPTH;
  end

  // Next-state and bus control decode.
  always_comb begin
    state_d   = state_q;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cti_o = CLASSIC;
    irq_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = WAIT;
      end
      WAIT: begin
        if (fifo_space >= burst_len_c) state_d = BURST;
      end
      BURST: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = !gap_q;
`ifdef WB_STREAM_WRITER_BURST_EN
        wbm_cti_o = last_beat ? EOB : INC;
`else
        wbm_cti_o = CLASSIC;
`endif
        if (bus_err)
          state_d = IDLE;
        else if (beat_ok && last_beat)
          state_d = (offset_q + ONE_W == buf_size_q) ? DONE : WAIT;
      end
      DONE: begin
        irq_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration, transfer progress and sticky error.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      base_adr_q   <= '0;
      buf_size_q   <= '0;
      burst_size_q <= '0;
      offset_q     <= '0;
      beat_cnt_q   <= '0;
      burst_len_q  <= '0;
      gap_q        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_ok) begin
        base_adr_q   <= start_adr;
        buf_size_q   <= buf_size;
        burst_size_q <= burst_size;
        offset_q     <= '0;
        err_o        <= 1'b0;
      end
      if (state_q == WAIT && state_d == BURST) begin
        burst_len_q <= burst_len_c;
        beat_cnt_q  <= '0;
      end
      if (beat_ok) begin
        offset_q   <= offset_q + ONE_W;
        beat_cnt_q <= beat_cnt_q + ONE_W;
      end
`ifdef WB_STREAM_WRITER_BURST_EN
      gap_q <= 1'b0;
`else
      gap_q <= beat_ok;
`endif
      if (bus_err) err_o <= 1'b1;
    end
  end

endmodule
